// File: rtl/wash_countdown_pkg.sv
// Shared definitions for the wash countdown timer: FSM encoding, blank display
// code and BCD digit limits.
package wash_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] BCD_MAX9   = 4'd9;
  localparam logic [3:0] BCD_MAX5   = 4'd5;

  function automatic logic [3:0] bcd_sat(input logic [3:0] val, input logic [3:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/wash_countdown_bcd_down_digit.sv
// One BCD down-counting digit with a programmable top value; borrow_o fires
// when a decrement wraps the digit from 0 back to max_i.
module bcd_down_digit
  import wash_countdown_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  input  logic [3:0] max_i,
  output logic [3:0] digit_o,
  output logic       borrow_o
);

  logic [3:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = 4'd0;
    end else if (load_i) begin
      digit_d = bcd_sat(load_val_i, max_i);
    end else if (dec_i) begin
      digit_d = (digit_q == 4'd0) ? max_i : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o  = digit_q;
  assign borrow_o = dec_i && (digit_q == 4'd0);

endmodule

// File: rtl/wash_countdown.sv
// MM:SS countdown controller with run/pause/done sequencing and BCD outputs.
// Define WASH_BLINK_EN to blank the display periodically while paused.
//   state | meaning
//   IDLE  | time loaded or cleared, waiting for start
//   RUN   | prescaler running, one-second ticks decrement time
//   PAUSE | time and prescaler frozen
//   DONE  | reached 00:00, waits for load or abort
module wash_countdown
  import wash_countdown_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic [3:0] seg3,
  output logic [3:0] seg2,
  output logic [3:0] seg1,
  output logic [3:0] seg0,
  output logic       running,
  output logic       done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  if (TICK_DIV < 1 || BLINK_DIV < 1) begin : g_bad_div
    $error("wash_countdown: TICK_DIV and BLINK_DIV must be at least 1");
  end

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          tick, load_en;
  logic [3:0]    dig3, dig2, dig1, dig0;
  logic          borrow0, borrow1, borrow2, borrow3;
  logic          time_zero, last_sec;
  logic          unused_borrow;

  assign time_zero = (dig3 == 4'd0) && (dig2 == 4'd0) && (dig1 == 4'd0) && (dig0 == 4'd0);
  assign last_sec  = (dig3 == 4'd0) && (dig2 == 4'd0) && (dig1 == 4'd0) && (dig0 == 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (!load && start && !time_zero) state_d = ST_RUN;
        ST_RUN: begin
          if (tick && last_sec) state_d = ST_DONE;
          else if (pause)       state_d = ST_PAUSE;
        end
        ST_PAUSE: if (start || pause) state_d = ST_RUN;
        ST_DONE:  if (load) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // The pause cycle itself still advances the prescaler; PAUSE then freezes it.
  always_comb begin
    tick    = (state_q == ST_RUN) && (presc_q == TICK_LAST) && !abort && !time_zero;
    load_en = !abort && load && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    presc_d = presc_q;
    if (abort) begin
      presc_d = '0;
    end else if (state_q == ST_RUN) begin
      presc_d = (presc_q == TICK_LAST) ? '0 : presc_q + 1'b1;
    end else if (state_q != ST_PAUSE) begin
      presc_d = '0;
    end
    done_d = (state_q == ST_RUN) && (state_d == ST_DONE);
  end

  bcd_down_digit u_sec_ones (
    .clk(clk), .rst_n(rst_n), .clr_i(abort), .load_i(load_en),
    .load_val_i(set_sec[3:0]), .dec_i(tick), .max_i(BCD_MAX9),
    .digit_o(dig0), .borrow_o(borrow0)
  );

  bcd_down_digit u_sec_tens (
    .clk(clk), .rst_n(rst_n), .clr_i(abort), .load_i(load_en),
    .load_val_i(set_sec[7:4]), .dec_i(borrow0), .max_i(BCD_MAX5),
    .digit_o(dig1), .borrow_o(borrow1)
  );

  bcd_down_digit u_min_ones (
    .clk(clk), .rst_n(rst_n), .clr_i(abort), .load_i(load_en),
    .load_val_i(set_min[3:0]), .dec_i(borrow1), .max_i(BCD_MAX9),
    .digit_o(dig2), .borrow_o(borrow2)
  );

  bcd_down_digit u_min_tens (
    .clk(clk), .rst_n(rst_n), .clr_i(abort), .load_i(load_en),
    .load_val_i(set_min[7:4]), .dec_i(borrow2), .max_i(BCD_MAX9),
    .digit_o(dig3), .borrow_o(borrow3)
  );

  // Ticks stop at 00:01 -> 00:00, so the top digit never borrows.
  assign unused_borrow = borrow3;

  assign running = (state_q == ST_RUN);
  assign done    = done_q;

`ifdef WASH_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blank_q, blank_d;

  always_comb begin
    blink_cnt_d = '0;
    blank_d     = 1'b0;
    if ((state_q == ST_PAUSE) && (state_d == ST_PAUSE)) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blank_d     = !blank_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blank_d     = blank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
    end
  end

  assign seg3 = blank_q ? BLANK_CODE : dig3;
  assign seg2 = blank_q ? BLANK_CODE : dig2;
  assign seg1 = blank_q ? BLANK_CODE : dig1;
  assign seg0 = blank_q ? BLANK_CODE : dig0;
`else
  assign seg3 = dig3;
  assign seg2 = dig2;
  assign seg1 = dig1;
  assign seg0 = dig0;
`endif

endmodule
